// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational ROM, buffers words in a prefetch FIFO.
// Optional macro FETCH_WRAP_EN: end of ROM wraps the PC to 0 instead of halting.
module fetch_sequencer #(
    parameter int N          = 32,
    parameter int DEPTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] rom_addr,
    input  logic [N-1:0] rom_instr,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_instr,
    output logic [N-1:0] out_pc,
    output logic         halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [AW-1:0] LAST_PC  = AW'(DEPTH - 1);
    localparam logic [5:0]    J_OPCODE = 6'b000010;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [N-1:0]    instr_q [FIFO_DEPTH];
    logic [N-1:0]    instr_d [FIFO_DEPTH];
    logic [AW-1:0]   epc_q [FIFO_DEPTH];
    logic [AW-1:0]   epc_d [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop_s;
    logic            push_s;
    logic            is_jump_s;
    logic [27:0]     jump_word_s;
    logic            unused_s;

    // Only the low AW bits of a redirect target address the ROM.
    assign unused_s = ^redirect_pc[N-1:AW];

    assign rom_addr  = {{(N-AW){1'b0}}, pc_q};
    assign out_valid = (count_q != ZERO_CNT);
    assign out_instr = out_valid ? instr_q[rd_ptr_q] : {N{1'b0}};
    assign out_pc    = out_valid ? {{(N-AW){1'b0}}, epc_q[rd_ptr_q]} : {N{1'b0}};
`ifdef FETCH_WRAP_EN
    assign halted    = 1'b0;
`else
    assign halted    = (state_q == ST_HALT);
`endif

    // Next-state: redirect flushes, otherwise pop head and push the current ROM word.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        epc_d       = epc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pop_s       = out_valid && out_ready;
        is_jump_s   = (rom_instr[31:26] == J_OPCODE);
        jump_word_s = {rom_instr[25:0], 2'b00};
        push_s      = !redirect_valid && (state_q == ST_RUN) && ((count_q != FULL_CNT) || pop_s);

        if (redirect_valid) begin
            // A simultaneous pop was already taken by downstream; everything else is discarded.
            count_d  = ZERO_CNT;
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            pc_d     = redirect_pc[AW-1:0];
            state_d  = ST_RUN;
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                instr_d[wr_ptr_q] = rom_instr;
                epc_d[wr_ptr_q]   = pc_q;
                wr_ptr_d          = wr_ptr_q + PW'(1);
                if (is_jump_s) begin
                    pc_d = jump_word_s[AW-1:0];
                end else if (pc_q == LAST_PC) begin
`ifdef FETCH_WRAP_EN
                    pc_d = {AW{1'b0}};
`else
                    state_d = ST_HALT;
`endif
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, PC and FIFO registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= {AW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= ZERO_CNT;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= {N{1'b0}};
                epc_q[i]   <= {AW{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                epc_q[i]   <= epc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: queue-based reference model plus directed and random scenarios.
module tb_fetch_sequencer;

    localparam int N     = 32;
    localparam int DEPTH = 32;
    localparam int FD    = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] rom_addr;
    logic [N-1:0] rom_instr;
    logic         redirect_valid = 1'b0;
    logic [N-1:0] redirect_pc = 32'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_instr;
    logic [N-1:0] out_pc;
    logic         halted;

    logic [31:0]  rom [DEPTH];

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  pc;
    } ent_t;

    ent_t mq[$];
    int   mpc;
    bit   mhalt;
    int   obs[$];
    int   checks = 0;
    int   errors = 0;

    assign rom_instr = rom[rom_addr[4:0]];

    always #5 clk = ~clk;

    fetch_sequencer #(.N(N), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_instr      (rom_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    function automatic logic [97:0] exp_out();
        if (mq.size() != 0)
            return {1'b1, 32'(mq[0].pc), mq[0].instr, mhalt, 32'(mpc)};
        else
            return {1'b0, 32'd0, 32'd0, mhalt, 32'(mpc)};
    endfunction

    function automatic void model_clear();
        mq.delete();
        mpc   = 0;
        mhalt = 1'b0;
    endfunction

    // Applies one clock of the reference rules to the model, then crosses the DUT edge.
    task automatic advance();
        logic [31:0] w;
        ent_t        e;
        if (out_valid && out_ready) obs.push_back(int'(out_pc));
        if ((mq.size() != 0) && out_ready) void'(mq.pop_front());
        if (redirect_valid) begin
            mq.delete();
            mpc   = int'(redirect_pc % DEPTH);
            mhalt = 1'b0;
        end else if (!mhalt && mq.size() < FD) begin
            w = rom[mpc];
            e.instr = w;
            e.pc    = 5'(mpc);
            mq.push_back(e);
            if (w[31:26] == 6'b000010) begin
                mpc = (int'(w[25:0]) * 4) % DEPTH;
            end else if (mpc == DEPTH - 1) begin
`ifdef FETCH_WRAP_EN
                mpc = 0;
`else
                mhalt = 1'b1;
`endif
            end else begin
                mpc = mpc + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [97:0] exp;
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA500_0000 | 32'(i);
        model_clear();
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr, halted, rom_addr} !== 98'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", {out_valid, out_pc, out_instr, halted, rom_addr});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        obs.delete();
        for (int i = 0; i < 5; i++) begin
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL reset_stream cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs.size() <= i || obs[i] != i) begin
                errors++;
                $display("FAIL reset_order idx %0d got %0d exp %0d", i, (obs.size() > i) ? obs[i] : -1, i);
            end
        end
    endtask

    task automatic test_jump();
        logic [97:0] exp;
        int          want [4];
        want = '{4, 5, 16, 17};
        rom[5] = 32'h0800_0004;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd4;
        advance();
        redirect_valid = 1'b0;
        obs.delete();
        for (int i = 0; i < 5; i++) begin
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL jump_stream cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs.size() <= i || obs[i] != want[i]) begin
                errors++;
                $display("FAIL jump_order idx %0d got %0d exp %0d", i, (obs.size() > i) ? obs[i] : -1, want[i]);
            end
        end
        rom[5] = 32'hA500_0005;
    endtask

    task automatic test_backpressure();
        logic [97:0] exp;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
        checks++;
        if (rom_addr !== 32'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full got addr %0d valid %b exp addr 2 valid 1", rom_addr, out_valid);
        end
        out_ready = 1'b1;
        obs.delete();
        for (int i = 0; i < 6; i++) begin
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL bp_resume cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs.size() <= i || obs[i] != i) begin
                errors++;
                $display("FAIL bp_order idx %0d got %0d exp %0d", i, (obs.size() > i) ? obs[i] : -1, i);
            end
        end
    endtask

    task automatic test_redirect();
        logic [97:0] exp;
        int          want [3];
        want = '{0, 20, 21};
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) advance();
        obs.delete();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd20;
        advance();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_bubble got valid %b exp 0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL redir_stream cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs.size() <= i || obs[i] != want[i]) begin
                errors++;
                $display("FAIL redir_order idx %0d got %0d exp %0d", i, (obs.size() > i) ? obs[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_end_of_rom();
        logic [97:0] exp;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd28;
        advance();
        redirect_valid = 1'b0;
        obs.delete();
        for (int i = 0; i < 6; i++) begin
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL eor_stream cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
`ifdef FETCH_WRAP_EN
        checks++;
        if (obs.size() < 5 || obs[3] != 31 || obs[4] != 0) begin
            errors++;
            $display("FAIL eor_wrap got size %0d exp 31 then 0", obs.size());
        end
`else
        checks++;
        if (out_valid !== 1'b0 || halted !== 1'b1 || rom_addr !== 32'd31) begin
            errors++;
            $display("FAIL eor_halt got valid %b halted %b addr %0d exp 0 1 31", out_valid, halted, rom_addr);
        end
`endif
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        advance();
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL eor_clear got halted %b exp 0", halted);
        end
    endtask

    task automatic test_random();
        logic [97:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = $urandom;
            if (rom[i][31:26] == 6'b000010) rom[i][31] = 1'b1;
            if ($urandom_range(7) == 0) rom[i] = {6'b000010, 26'($urandom)};
        end
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(15) == 0);
            redirect_pc    = $urandom;
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL random cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [97:0] exp;
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h3C00_0000 | 32'(i * 3);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) advance();
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr, halted, rom_addr} !== 98'd0) begin
            errors++;
            $display("FAIL reset_mid_async got %h exp 0", {out_valid, out_pc, out_instr, halted, rom_addr});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        advance();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== rom[0]) begin
            errors++;
            $display("FAIL reset_mid_restart got valid %b pc %0d instr %h exp 1 0 %h", out_valid, out_pc, out_instr, rom[0]);
        end
        for (int i = 0; i < 4; i++) begin
            advance();
            exp = exp_out();
            checks++;
            if ({out_valid, out_pc, out_instr, halted, rom_addr} !== exp) begin
                errors++;
                $display("FAIL reset_mid_stream cyc %0d got %h exp %h", i, {out_valid, out_pc, out_instr, halted, rom_addr}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_backpressure();
        test_redirect();
        test_end_of_rom();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
